// File: rtl/physics_frame_scheduler.sv
// physics_frame_scheduler: frame tick -> collision pass -> per-pin update sequencer.
// Optional SKIP_IDLE_PINS_EN: issue updates only for pins flagged in the hit mask.
module physics_frame_scheduler #(
  parameter int NUM_PINS     = 10,
  parameter int IDX_W        = 4,
  parameter int TICK_CYCLES  = 750000,
  parameter int COLL_TIMEOUT = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic                clr_in,
  output logic                coll_start_out,
  input  logic                coll_done_in,
  input  logic [NUM_PINS-1:0] coll_hit_in,
  output logic                upd_valid_out,
  output logic [IDX_W-1:0]    upd_idx_out,
  input  logic                upd_ready_in,
  output logic [NUM_PINS-1:0] hit_mask_out,
  output logic                frame_done_out,
  output logic                busy_out,
  output logic                timeout_out,
  output logic [7:0]          overrun_count_out,
  output logic [15:0]         frame_count_out
);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int CW = $clog2(COLL_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLIDE, UPDATE, FINISH} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] to_cnt;
  logic [IDX_W-1:0] idx, first_hit, next_hit;
  logic tick, done_evt, timeout_evt, xfer, last, ovr;
  assign tick = enable_in && (tick_cnt == TW'(TICK_CYCLES - 1));
  // done is ignored in the start cycle so a stale done from the engine cannot end the pass
  assign done_evt = (state == COLLIDE) && !coll_start_out && coll_done_in;
  assign timeout_evt = (state == COLLIDE) && !done_evt && (to_cnt == CW'(COLL_TIMEOUT - 1));
  assign ovr = tick && (state != IDLE);
  assign xfer = upd_valid_out && upd_ready_in;
  assign busy_out = state != IDLE;
  assign frame_done_out = state == FINISH;
  assign upd_idx_out = idx;
`ifdef SKIP_IDLE_PINS_EN
  logic [NUM_PINS-1:0] mask_sh;
  logic has_next;
  assign mask_sh = hit_mask_out >> idx;
  assign upd_valid_out = (state == UPDATE) && mask_sh[0];
  assign last = !has_next;
  always_comb begin
    first_hit = '0;
    next_hit = '0;
    has_next = 1'b0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (coll_hit_in[i]) first_hit = IDX_W'(i);
      if (hit_mask_out[i] && IDX_W'(i) > idx) begin
        next_hit = IDX_W'(i);
        has_next = 1'b1;
      end
    end
  end
`else
  assign upd_valid_out = state == UPDATE;
  assign last = idx == IDX_W'(NUM_PINS - 1);
  assign first_hit = '0;
  assign next_hit = idx + 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = tick ? COLLIDE : IDLE;
      COLLIDE: state_nxt = done_evt ? UPDATE : timeout_evt ? FINISH : COLLIDE;
      // an empty mask in skip mode leaves valid low, which ends the update phase at once
      UPDATE:  state_nxt = (!upd_valid_out || (xfer && last)) ? FINISH : UPDATE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      tick_cnt          <= '0;
      to_cnt            <= '0;
      idx               <= '0;
      coll_start_out    <= 1'b0;
      hit_mask_out      <= '0;
      timeout_out       <= 1'b0;
      overrun_count_out <= '0;
      frame_count_out   <= '0;
    end else begin
      state             <= state_nxt;
      tick_cnt          <= (!enable_in || tick) ? '0 : tick_cnt + 1'b1;
      to_cnt            <= (state == COLLIDE) ? to_cnt + 1'b1 : '0;
      coll_start_out    <= (state == IDLE) && tick;
      hit_mask_out      <= done_evt ? coll_hit_in : timeout_evt ? '0 : hit_mask_out;
      idx               <= done_evt ? first_hit : (state == FINISH) ? '0 :
                           (state == UPDATE && xfer && !last) ? next_hit : idx;
      timeout_out       <= timeout_evt ? 1'b1 : clr_in ? 1'b0 : timeout_out;
      overrun_count_out <= ovr ? (clr_in ? 8'd1 : (&overrun_count_out) ? overrun_count_out : overrun_count_out + 8'd1) :
                           clr_in ? 8'd0 : overrun_count_out;
      frame_count_out   <= (state == FINISH) ? frame_count_out + 16'd1 : frame_count_out;
    end
  end
endmodule

// File: tb/tb_physics_frame_scheduler.sv
// tb_physics_frame_scheduler: directed checks of frame sequencing, stalls, timeout, overrun and async reset.
module tb_physics_frame_scheduler;
  logic clk_in = 1'b0, rst_in = 1'b1, enable_in = 1'b0, clr_in = 1'b0;
  logic coll_done_in = 1'b0, upd_ready_in = 1'b0;
  logic [9:0] coll_hit_in = '0;
  logic coll_start_out, upd_valid_out, frame_done_out, busy_out, timeout_out;
  logic [3:0] upd_idx_out;
  logic [9:0] hit_mask_out;
  logic [7:0] overrun_count_out;
  logic [15:0] frame_count_out;
  int n_checks = 0, n_fail = 0;
  int xfers [10];
  int exp_idx [10];
  int n_upd;
  logic saw_valid;

  physics_frame_scheduler #(.NUM_PINS(10), .IDX_W(4), .TICK_CYCLES(16), .COLL_TIMEOUT(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .clr_in(clr_in),
    .coll_start_out(coll_start_out), .coll_done_in(coll_done_in), .coll_hit_in(coll_hit_in),
    .upd_valid_out(upd_valid_out), .upd_idx_out(upd_idx_out), .upd_ready_in(upd_ready_in),
    .hit_mask_out(hit_mask_out), .frame_done_out(frame_done_out), .busy_out(busy_out),
    .timeout_out(timeout_out), .overrun_count_out(overrun_count_out), .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!coll_start_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk("start_seen", coll_start_out, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, coll_start_out, 0);
    chk({tag, "_valid"}, upd_valid_out, 0);
    chk({tag, "_idx"}, upd_idx_out, 0);
    chk({tag, "_mask"}, hit_mask_out, 0);
    chk({tag, "_done"}, frame_done_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_timeout"}, timeout_out, 0);
    chk({tag, "_overrun"}, overrun_count_out, 0);
    chk({tag, "_frames"}, frame_count_out, 0);
  endtask

  initial begin
    // reset state
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    enable_in = 1'b1;
    // frame 1: start in cycle 17, done 3 cycles after start, hit 10'h005
    repeat (15) @(negedge clk_in);
    chk("t1_no_start_yet", coll_start_out, 0);
    chk("t1_idle", busy_out, 0);
    @(negedge clk_in);
    chk("t1_start", coll_start_out, 1);
    chk("t1_busy", busy_out, 1);
    enable_in = 1'b0;
    upd_ready_in = 1'b1;
    @(negedge clk_in);
    chk("t1_start_one_cycle", coll_start_out, 0);
    repeat (2) @(negedge clk_in);
    coll_done_in = 1'b1;
    coll_hit_in = 10'h005;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    coll_hit_in = '0;
    chk("t1_mask", hit_mask_out, 10'h005);
`ifdef SKIP_IDLE_PINS_EN
    n_upd = 2;
    exp_idx[0] = 0;
    exp_idx[1] = 2;
`else
    n_upd = 10;
    for (int i = 0; i < 10; i++) exp_idx[i] = i;
`endif
    for (int k = 0; k < n_upd; k++) begin
      chk("t1_valid", upd_valid_out, 1);
      chk("t1_idx", upd_idx_out, exp_idx[k]);
      @(negedge clk_in);
    end
    chk("t1_frame_done", frame_done_out, 1);
    chk("t1_valid_off", upd_valid_out, 0);
    @(negedge clk_in);
    chk("t1_done_one_cycle", frame_done_out, 0);
    chk("t1_frames", frame_count_out, 1);
    chk("t1_idle_after", busy_out, 0);
    // frame 2: engine never finishes; clr in the timeout cycle loses to the event
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    saw_valid = 1'b0;
    for (int k = 2; k <= 64; k++) begin
      @(negedge clk_in);
      if (upd_valid_out) saw_valid = 1'b1;
    end
    chk("t2_no_timeout_yet", timeout_out, 0);
    chk("t2_still_colliding", busy_out, 1);
    clr_in = 1'b1;
    @(negedge clk_in);
    clr_in = 1'b0;
    chk("t2_timeout", timeout_out, 1);
    chk("t2_frame_done", frame_done_out, 1);
    chk("t2_mask_cleared", hit_mask_out, 0);
    chk("t2_no_valid", saw_valid | upd_valid_out, 0);
    @(negedge clk_in);
    chk("t2_frames", frame_count_out, 2);
    chk("t2_sticky", timeout_out, 1);
    clr_in = 1'b1;
    @(negedge clk_in);
    clr_in = 1'b0;
    chk("t2_clr", timeout_out, 0);
    // frame 3: ready low for 5 cycles while index 3 is presented
    for (int i = 0; i < 10; i++) xfers[i] = 0;
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    coll_hit_in = 10'h3ff;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    for (int c = 0; c < 15; c++) begin
      upd_ready_in = !(c >= 3 && c <= 7);
      chk("t3_valid", upd_valid_out, 1);
      chk("t3_idx", upd_idx_out, c < 3 ? c : (c <= 8 ? 3 : c - 5));
      if (upd_ready_in && upd_idx_out < 10) xfers[upd_idx_out]++;
      @(negedge clk_in);
    end
    chk("t3_frame_done", frame_done_out, 1);
    for (int i = 0; i < 10; i++) chk("t3_xfer_once", xfers[i], 1);
    @(negedge clk_in);
    chk("t3_frames", frame_count_out, 3);
    // frame 4: ready held low, ticks keep coming -> overrun counting and saturation
    upd_ready_in = 1'b0;
    enable_in = 1'b1;
    wait_start();
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    repeat (36) @(negedge clk_in);
    chk("t4_overrun2", overrun_count_out, 2);
    chk("t4_in_update", upd_valid_out, 1);
    chk("t4_idx_held", upd_idx_out, 0);
    repeat (4060) @(negedge clk_in);
    chk("t4_saturated", overrun_count_out, 255);
    repeat (11) @(negedge clk_in);
    clr_in = 1'b1;
    @(negedge clk_in);
    chk("t4_clr_with_overrun", overrun_count_out, 1);
    @(negedge clk_in);
    clr_in = 1'b0;
    chk("t4_clr_plain", overrun_count_out, 0);
    enable_in = 1'b0;
    upd_ready_in = 1'b1;
    repeat (11) @(negedge clk_in);
    chk("t4_idle", busy_out, 0);
    chk("t4_frames", frame_count_out, 4);
    // frame 5: async reset while index 6 is presented
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("t5_idx6", upd_idx_out, 6);
    #2 rst_in = 1'b1;
    #1 chk_all_zero("t5_async");
    @(negedge clk_in);
    rst_in = 1'b0;
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    chk("t5_restart_idx", upd_idx_out, 0);
    chk("t5_restart_valid", upd_valid_out, 1);
    repeat (10) @(negedge clk_in);
    chk("t5_frame_done", frame_done_out, 1);
    @(negedge clk_in);
    chk("t5_frames", frame_count_out, 1);
`ifdef SKIP_IDLE_PINS_EN
    // sparse mask: only pins 0 and 9
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    coll_hit_in = 10'h201;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    chk("s1_valid0", upd_valid_out, 1);
    chk("s1_idx0", upd_idx_out, 0);
    @(negedge clk_in);
    chk("s1_valid9", upd_valid_out, 1);
    chk("s1_idx9", upd_idx_out, 9);
    @(negedge clk_in);
    chk("s1_frame_done", frame_done_out, 1);
    @(negedge clk_in);
    chk("s1_frames", frame_count_out, 2);
    // empty mask: one idle update cycle then finish
    enable_in = 1'b1;
    wait_start();
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    coll_done_in = 1'b1;
    coll_hit_in = 10'h000;
    @(negedge clk_in);
    coll_done_in = 1'b0;
    chk("s2_update_busy", busy_out, 1);
    chk("s2_no_valid", upd_valid_out, 0);
    chk("s2_not_done_yet", frame_done_out, 0);
    @(negedge clk_in);
    chk("s2_frame_done", frame_done_out, 1);
    @(negedge clk_in);
    chk("s2_frames", frame_count_out, 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
